// File: rtl/ddr_bw_pkg.sv
// rtl/ddr_bw_pkg.sv - shared types, burst geometry and cfg field offsets for the DDR burst engine
package ddr_bw_pkg;

    typedef enum logic {DIR_WR = 1'b0, DIR_RD = 1'b1} dir_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    localparam int BURST_LEN  = 8;
    localparam int BEAT_BYTES = 8;

    localparam int OFF_BASE = 0;
    localparam int OFF_N    = 32;
    localparam int OFF_SEED = 64;
    localparam int OFF_OPER = 224;

endpackage

// File: rtl/ddr_burst_engine_if.sv
// rtl/ddr_burst_engine_if.sv - AXI4 master bundle (AW/W/B/AR/R) between the burst engine and the HP port
interface ddr_burst_engine_if #(parameter int AW = 32) ();
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          awvalid;
    logic          awready;
    logic [63:0]   wdata;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          arvalid;
    logic          arready;
    logic [63:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awlen, awvalid, input awready,
        output wdata, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arlen, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awvalid, output awready,
        input wdata, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arlen, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/ddr_bw_pattern.sv
// rtl/ddr_bw_pattern.sv - test word for global beat idx: {seed+idx, ~(seed+idx)} with 32-bit wrap
module ddr_bw_pattern (
    input  logic [31:0] seed,
    input  logic [31:0] idx,
    output logic [63:0] word
);
    logic [31:0] val;

    assign val  = seed + idx;
    assign word = {val, ~val};
endmodule

// File: rtl/ddr_burst_engine.sv
// rtl/ddr_burst_engine.sv - cfg-driven DDR bandwidth job engine (N x 8-beat INCR bursts, write or read)
// Optional read-data compare against the beat pattern when DDR_BW_CHECK_EN is defined.
module ddr_burst_engine
    import ddr_bw_pkg::*;
#(
    parameter int FW        = 242,
    parameter int AW        = 32,
    parameter int MAX_OUTST = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_valid,
    input  logic [FW-1:0]       cfg_data,
    output logic                cfg_ready,
    ddr_burst_engine_if.master  m_axi,
    output logic                busy,
    output logic                done,
    output logic [31:0]         cycles,
    output logic [15:0]         err_cnt
);
    localparam int OW = $clog2(MAX_OUTST) + 1;

    state_t        state, state_nxt;
    dir_t          dir;
    logic [AW-1:0] base;
    logic [31:0]   n, seed, issued, cmpl, w_burst;
    logic [2:0]    w_beat;
    logic [OW-1:0] outst;
    logic          run, accept, addr_ok, addr_hs, w_hs, b_hs, r_hs, cmpl_evt;
    logic          b_err, r_err, chk_err;
    logic [63:0]   w_word;
    logic [16:0]   err_sum;
    logic [AW-1:0] addr;

    assign run       = (state == RUN);
    assign cfg_ready = (state == IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    assign addr_ok         = run && (issued < n) && (outst < OW'(MAX_OUTST));
    assign addr            = base + AW'({issued[25:0], 6'd0});
    assign m_axi.awaddr    = addr;
    assign m_axi.araddr    = addr;
    assign m_axi.awlen     = 8'd7;
    assign m_axi.arlen     = 8'd7;
    assign m_axi.awvalid   = addr_ok && (dir == DIR_WR);
    assign m_axi.arvalid   = addr_ok && (dir == DIR_RD);
    assign addr_hs         = (m_axi.awvalid && m_axi.awready) || (m_axi.arvalid && m_axi.arready);
    assign m_axi.bready    = 1'b1;
    assign m_axi.rready    = 1'b1;

    // A beat may only go out once its burst's AW has handshaken.
    assign m_axi.wvalid = run && (dir == DIR_WR) && (w_burst < issued);
    assign m_axi.wlast  = m_axi.wvalid && (w_beat == 3'd7);
    assign m_axi.wdata  = m_axi.wvalid ? w_word : 64'd0;
    assign w_hs         = m_axi.wvalid && m_axi.wready;

    ddr_bw_pattern u_wpat (
        .seed (seed),
        .idx  ({w_burst[28:0], w_beat}),
        .word (w_word)
    );

    assign b_hs     = run && (dir == DIR_WR) && m_axi.bvalid;
    assign r_hs     = run && (dir == DIR_RD) && m_axi.rvalid;
    assign cmpl_evt = b_hs || (r_hs && m_axi.rlast);
    assign b_err    = b_hs && (m_axi.bresp != 2'b00);
    assign r_err    = r_hs && (m_axi.rresp != 2'b00);

`ifdef DDR_BW_CHECK_EN
    logic [31:0] r_beat;
    logic [63:0] r_word;

    ddr_bw_pattern u_rpat (
        .seed (seed),
        .idx  (r_beat),
        .word (r_word)
    );

    assign chk_err = r_hs && (m_axi.rdata != r_word);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       r_beat <= '0;
        else if (accept) r_beat <= '0;
        else if (r_hs)   r_beat <= r_beat + 32'd1;
    end

    logic unused_ok;
    assign unused_ok = ^{cfg_data[FW-1:OFF_OPER+1], cfg_data[OFF_OPER-1:OFF_SEED+32], w_burst[31:29]};
`else
    assign chk_err = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{cfg_data[FW-1:OFF_OPER+1], cfg_data[OFF_OPER-1:OFF_SEED+32], w_burst[31:29],
                         m_axi.rdata};
`endif

    assign err_sum = {1'b0, err_cnt} + 17'(b_err) + 17'(r_err) + 17'(chk_err);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_valid) state_nxt = (cfg_data[OFF_N +: 32] == 32'd0) ? FIN : RUN;
            RUN:     if (cmpl_evt && (cmpl + 32'd1 == n)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dir     <= DIR_WR;
            base    <= '0;
            n       <= '0;
            seed    <= '0;
            issued  <= '0;
            cmpl    <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            outst   <= '0;
            cycles  <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            dir     <= dir_t'(cfg_data[OFF_OPER]);
            base    <= cfg_data[OFF_BASE +: AW] & ~AW'(63);
            n       <= cfg_data[OFF_N +: 32];
            seed    <= cfg_data[OFF_SEED +: 32];
            issued  <= '0;
            cmpl    <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            outst   <= '0;
            cycles  <= '0;
            err_cnt <= '0;
        end else begin
            if (addr_hs)  issued <= issued + 32'd1;
            if (cmpl_evt) cmpl   <= cmpl + 32'd1;
            if (w_hs) begin
                w_beat <= w_beat + 3'd1;
                if (w_beat == 3'd7) w_burst <= w_burst + 32'd1;
            end
            // Simultaneous issue and completion leave the outstanding count unchanged.
            if (addr_hs && !cmpl_evt)                      outst <= outst + OW'(1);
            else if (!addr_hs && cmpl_evt && outst != '0)  outst <= outst - OW'(1);
            if (run && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
endmodule

// File: tb/tb_ddr_burst_engine.sv
// tb/tb_ddr_burst_engine.sv - randomized bench for ddr_burst_engine with an AXI slave and job-level reference model
module tb_ddr_burst_engine;
    localparam int FW        = 242;
    localparam int AW        = 32;
    localparam int MAX_OUTST = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_valid;
    logic [FW-1:0] cfg_data;
    logic          cfg_ready, busy, done;
    logic [31:0]   cycles;
    logic [15:0]   err_cnt;

    ddr_burst_engine_if #(.AW(AW)) axi ();

    ddr_burst_engine #(.FW(FW), .AW(AW), .MAX_OUTST(MAX_OUTST)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .m_axi     (axi),
        .busy      (busy),
        .done      (done),
        .cycles    (cycles),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_rd, r_hold, rand_err, always_rdy;
    logic [31:0] m_base, m_seed;
    int          m_n, bad_b, corrupt;
    int          aw_cnt, ar_cnt, w_cnt, b_sent, rb_sent, exp_err, run_cnt;
    int          aw_prev, ar_prev, w_prev, b_prev, rb_prev;
    logic [63:0] rword;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] s, input int j);
        logic [31:0] v;
        v = s + 32'(j);
        return {v, ~v};
    endfunction

    function automatic logic [31:0] exp_addr(input int k);
        return (m_base & 32'hFFFF_FFC0) + 32'(k) * 32'd64;
    endfunction

    function automatic bit rdy();
        return always_rdy ? 1'b1 : ($urandom_range(3) != 0);
    endfunction

    initial begin : slave
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0;
        axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; axi.rdata = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                axi.awready = 0; axi.wready = 0; axi.arready = 0;
                axi.bvalid = 0; axi.rvalid = 0; axi.rlast = 0;
                aw_cnt = 0; ar_cnt = 0; w_cnt = 0; b_sent = 0; rb_sent = 0;
                continue;
            end
            aw_prev = aw_cnt; ar_prev = ar_cnt; w_prev = w_cnt; b_prev = b_sent; rb_prev = rb_sent;

            axi.wready = rdy();
            if (axi.wvalid && axi.wready) begin
                chk("w_after_aw", 64'(w_cnt / 8 < aw_prev), 64'd1);
                chk("wdata", axi.wdata, pat(m_seed, w_cnt));
                chk("wlast", 64'(axi.wlast), 64'(w_cnt % 8 == 7));
                w_cnt++;
            end
            axi.awready = rdy();
            if (axi.awvalid && axi.awready) begin
                chk("awaddr", 64'(axi.awaddr), 64'(exp_addr(aw_cnt)));
                chk("aw_outst", 64'(aw_cnt - b_prev < MAX_OUTST), 64'd1);
                aw_cnt++;
            end
            axi.bvalid = 0; axi.bresp = 0;
            if (w_prev / 8 > b_sent && rdy()) begin
                axi.bvalid = 1;
                if (b_sent == bad_b || (rand_err && $urandom_range(7) == 0)) begin
                    axi.bresp = 2'b10;
                    exp_err++;
                end
                b_sent++;
            end
            axi.arready = rdy();
            if (axi.arvalid && axi.arready) begin
                chk("araddr", 64'(axi.araddr), 64'(exp_addr(ar_cnt)));
                chk("ar_outst", 64'(ar_cnt - rb_prev / 8 < MAX_OUTST), 64'd1);
                ar_cnt++;
            end
            axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; axi.rdata = 0;
            if (!r_hold && rb_sent < ar_prev * 8 && rdy()) begin
                rword = pat(m_seed, rb_sent);
                if (rb_sent == corrupt) begin
                    rword = rword ^ 64'h100;
`ifdef DDR_BW_CHECK_EN
                    exp_err++;
`endif
                end
                if (rand_err && $urandom_range(15) == 0) begin
                    axi.rresp = 2'b10;
                    exp_err++;
                end
                axi.rdata = rword;
                axi.rlast = (rb_sent % 8 == 7);
                axi.rvalid = 1;
                rb_sent++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (busy && !done) run_cnt++;
    endtask

    task automatic start_job(input bit rd, input logic [31:0] base, input int n, input logic [31:0] seed,
                             input int bb, input int cb);
        logic [FW-1:0] c;
        #1;
        m_rd = rd; m_base = base; m_n = n; m_seed = seed; bad_b = bb; corrupt = cb;
        aw_cnt = 0; ar_cnt = 0; w_cnt = 0; b_sent = 0; rb_sent = 0; exp_err = 0; run_cnt = 0;
        for (int i = 0; i < FW; i += 32) c[i +: 32] = $urandom;
        c[31:0] = base; c[63:32] = 32'(n); c[95:64] = seed; c[224] = rd;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = c;
        chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_done();
        int lat;
        bit seen;
        lat = 0; seen = 0;
        tick();
        lat++;
        chk("busy_after_accept", 64'({busy, cfg_ready}), 64'b10);
        for (int i = 0; i < 5000 && !done; i++) begin
            tick();
            lat++;
        end
        seen = done;
        chk("job_done", 64'(seen), 64'd1);
        if (m_n == 0) chk("n0_latency", 64'(lat), 64'd1);
        chk("aw_cnt", 64'(aw_cnt), 64'(m_rd ? 0 : m_n));
        chk("ar_cnt", 64'(ar_cnt), 64'(m_rd ? m_n : 0));
        chk("w_beats", 64'(w_cnt), 64'(m_rd ? 0 : 8 * m_n));
        chk("r_beats", 64'(rb_sent), 64'(m_rd ? 8 * m_n : 0));
        chk("err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("cycles", 64'(cycles), 64'(run_cnt));
        tick();
        chk("done_pulse", 64'({done, busy, cfg_ready}), 64'b001);
    endtask

    task automatic run_job(input bit rd, input logic [31:0] base, input int n, input logic [31:0] seed,
                           input int bb, input int cb);
        start_job(rd, base, n, seed, bb, cb);
        wait_done();
    endtask

    initial begin
        rstn = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        r_hold = 0; rand_err = 0; always_rdy = 0; bad_b = -1; corrupt = -1;
        m_rd = 0; m_base = 0; m_seed = 0; m_n = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_status", 64'({cfg_ready, busy, done}), 64'b100);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_err", 64'(err_cnt), 64'd0);
        chk("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'd0);
        chk("rst_readies", 64'({axi.bready, axi.rready}), 64'b11);
        chk("rst_addr_data", {axi.awaddr, axi.araddr} | axi.wdata, 64'd0);
        rstn = 1'b1;

        always_rdy = 1;
        run_job(0, 32'h1000_0000, 4, 32'h10, -1, -1);
        always_rdy = 0;

        r_hold = 1;
        start_job(1, 32'h2000_0000, 20, $urandom, -1, -1);
        repeat (40) tick();
        chk("ar_window", 64'(ar_cnt), 64'd8);
        chk("ar_blocked", 64'(axi.arvalid), 64'd0);
        r_hold = 0;
        wait_done();

        run_job(0, 32'h3000_0000, 0, $urandom, -1, -1);
        run_job(0, 32'h0000_1003, 1, $urandom, -1, -1);
        run_job(0, 32'h4000_0000, 3, $urandom, 1, -1);
        run_job(1, 32'hFFFF_FFC0, 2, $urandom, -1, -1);
        run_job(0, 32'hFFFF_FFC0, 2, $urandom, -1, -1);

        start_job(1, 32'h5000_0000, 10, $urandom, -1, -1);
        repeat (15) tick();
        #2 rstn = 1'b0;
        #1;
        chk("arst_status", 64'({cfg_ready, busy, done}), 64'b100);
        chk("arst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'd0);
        chk("arst_counts", 64'({cycles, err_cnt}), 64'd0);
        chk("arst_addr", 64'(axi.araddr), 64'd0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        run_job(0, 32'h6000_0000, 5, $urandom, -1, -1);

        run_job(1, 32'h7000_0000, 2, $urandom, -1, 9);

        rand_err = 1;
        for (int i = 0; i < 6; i++)
            run_job(1'($urandom_range(1)), $urandom, $urandom_range(12), $urandom, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
